// File: rtl/fetch_seq.sv
// fetch_seq: multi-cycle instruction sequencer (FETCH -> WAIT -> EXEC -> COMMIT, HALT).
// Fetches over a valid/ready memory port with variable latency. It holds the fetched
// instruction for EXEC_CYCLES cycles, then emits one commit strobe per instruction.
//
// Optional feature: define FETCH_SEQ_TRAP_EN to trap on a misaligned next PC. The PC is not
// updated, a sticky trap flag is set and the sequencer halts. If the macro is undefined,
// trap_o is tied low.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   imem_req_valid_o/_ready_i, imem_addr_o          fetch request channel
//   imem_resp_valid_i, imem_resp_data_i             fetch response channel
//   redirect_i, target_i, halt_req_i                sampled only in COMMIT
//   pc_o, pc_add4_o, inst_o                         current PC, PC + PC_INC, latched instruction
//   exec_phase_o, commit_o, halted_o, trap_o        status / strobes
module fetch_seq #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h8000_0000),
  parameter int unsigned     PC_INC       = 4,
  parameter int unsigned     EXEC_CYCLES  = 1  // legal range 1..15
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_resp_valid_i,
  input  logic [31:0]     imem_resp_data_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] target_i,
  input  logic            halt_req_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_add4_o,
  output logic [31:0]     inst_o,
  output logic            exec_phase_o,
  output logic            commit_o,
  output logic            halted_o,
  output logic            trap_o
);

  localparam logic [2:0] StFetch  = 3'd0;
  localparam logic [2:0] StWait   = 3'd1;
  localparam logic [2:0] StExec   = 3'd2;
  localparam logic [2:0] StCommit = 3'd3;
  localparam logic [2:0] StHalt   = 3'd4;

  localparam logic [31:0] InstNop  = 32'h0000_0013;
  // Counter counts down to zero, so EXEC lasts exactly EXEC_CYCLES cycles.
  localparam logic [3:0]  ExecLoad = 4'(EXEC_CYCLES - 1);

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] pc_add4;
  logic [XLEN-1:0] next_pc;

  assign pc_add4 = pc_q + XLEN'(PC_INC);  // wraps modulo 2^XLEN
  assign next_pc = redirect_i ? target_i : pc_add4;

`ifdef FETCH_SEQ_TRAP_EN
  logic trap_q, trap_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
`ifdef FETCH_SEQ_TRAP_EN
    trap_d  = trap_q;
`endif
    case (state_q)
      StFetch: begin
        if (imem_req_ready_i) state_d = StWait;
      end
      StWait: begin
        // Responses are only accepted here; anything seen in other states is dropped.
        if (imem_resp_valid_i) begin
          inst_d  = imem_resp_data_i;
          cnt_d   = ExecLoad;
          state_d = StExec;
        end
      end
      StExec: begin
        if (cnt_q == 4'd0) state_d = StCommit;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StCommit: begin
`ifdef FETCH_SEQ_TRAP_EN
        // Misaligned target wins over halt_req and leaves pc pointing at the faulting instr.
        if (next_pc[1:0] != 2'b00) begin
          trap_d  = 1'b1;
          state_d = StHalt;
        end else begin
          pc_d    = next_pc;
          state_d = halt_req_i ? StHalt : StFetch;
        end
`else
        pc_d    = next_pc;
        state_d = halt_req_i ? StHalt : StFetch;
`endif
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StFetch;
      pc_q    <= RESET_VECTOR;
      inst_q  <= InstNop;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FETCH_SEQ_TRAP_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) trap_q <= 1'b0;
    else         trap_q <= trap_d;
  end
  assign trap_o = trap_q;
`else
  assign trap_o = 1'b0;
`endif

  assign imem_req_valid_o = (state_q == StFetch);
  assign imem_addr_o      = pc_q;
  assign pc_o             = pc_q;
  assign pc_add4_o        = pc_add4;
  assign inst_o           = inst_q;
  assign exec_phase_o     = (state_q == StExec) || (state_q == StCommit);
  assign commit_o         = (state_q == StCommit);
  assign halted_o         = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_seq.sv
// Testbench for fetch_seq. The stimulus side plays a variable-latency memory and pushes the
// expected fetch addresses and commit records into queues. A monitor pops and compares them
// whenever the DUT accepts a request or raises commit.
module tb_fetch_seq;
  localparam int unsigned EC  = 3;
  localparam logic [31:0] RV  = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_SEQ_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid, req_ready, resp_valid, redirect, halt_req;
  logic [31:0] addr, resp_data, target, pc, pc_add4, inst;
  logic exec_phase, commit, halted, trap;

  always #5 clk = ~clk;

  fetch_seq #(
    .XLEN        (32),
    .RESET_VECTOR(RV),
    .PC_INC      (4),
    .EXEC_CYCLES (EC)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .imem_req_valid_o (req_valid),
    .imem_req_ready_i (req_ready),
    .imem_addr_o      (addr),
    .imem_resp_valid_i(resp_valid),
    .imem_resp_data_i (resp_data),
    .redirect_i       (redirect),
    .target_i         (target),
    .halt_req_i       (halt_req),
    .pc_o             (pc),
    .pc_add4_o        (pc_add4),
    .inst_o           (inst),
    .exec_phase_o     (exec_phase),
    .commit_o         (commit),
    .halted_o         (halted),
    .trap_o           (trap)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    int          cyc;
  } exp_t;

  exp_t        cq[$];
  logic [31:0] fq[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] mpc;
  logic [31:0] minst;
  logic        mhalt;
  logic        mtrap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard
  int   cnt  = 0;
  int   ecnt = 0;
  exp_t me;
  always @(negedge clk) begin
    if (!rst_n) begin
      cnt  = 0;
      ecnt = 0;
    end else begin
      cnt++;
      if (exec_phase) ecnt++;
      if (req_valid && req_ready) begin
        if (fq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_fetch: got addr %h expected no request", addr);
        end else begin
          check("fetch_addr", addr, fq.pop_front());
        end
      end
      if (commit) begin
        if (cq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_commit: got 1 expected 0 (pc %h)", pc);
        end else begin
          me = cq.pop_front();
          check("commit_pc", pc, me.pc);
          check("commit_inst", inst, me.inst);
          check("commit_pc_add4", pc_add4, me.pc + 32'd4);
          check("commit_cycles", 32'(cnt), 32'(me.cyc));
          check("exec_phase_cycles", 32'(ecnt), 32'(EC + 1));
        end
        cnt  = 0;
        ecnt = 0;
      end
    end
  end

  // One instruction as seen by the memory: d1 cycles of ready=0, then d2 cycles until the
  // response (d2 >= 1). Expected length: (d1+1) FETCH + d2 WAIT + EC EXEC + 1 COMMIT.
  task automatic do_instr(input int d1, input int d2, input logic [31:0] dat, input logic r,
                          input logic [31:0] t, input logic h, input bit junk);
    int n = 0;
    logic [31:0] nxt;
    exp_t e;
    while (!req_valid && n < 20) begin
      tick();
      n++;
    end
    if (!req_valid) begin
      n_tests++; n_fail++;
      $display("FAIL fetch_timeout: got req_valid 0 expected 1");
      return;
    end
    fq.push_back(mpc);
    for (int i = 0; i < d1; i++) begin
      req_ready  = 1'b0;
      resp_valid = 1'b1;  // stray response outside WAIT must be ignored
      resp_data  = $urandom;
      tick();
    end
    req_ready  = 1'b1;
    resp_valid = 1'b0;
    tick();
    req_ready = 1'($urandom_range(0, 1));
    for (int i = 0; i < d2 - 1; i++) begin
      resp_valid = 1'b0;
      tick();
    end
    resp_valid = 1'b1;
    resp_data  = dat;
    e.pc   = mpc;
    e.inst = dat;
    e.cyc  = d1 + 1 + d2 + int'(EC) + 1;
    cq.push_back(e);
    tick();
    req_ready  = 1'b0;
    resp_valid = 1'b1;
    resp_data  = $urandom;
    for (int i = 0; i < int'(EC); i++) begin
      redirect = junk;
      target   = $urandom;
      halt_req = junk;
      tick();
    end
    redirect = r;
    target   = t;
    halt_req = h;
    tick();
    redirect   = 1'b0;
    halt_req   = 1'b0;
    resp_valid = 1'b0;
    target     = $urandom;
    nxt   = r ? t : mpc + 32'd4;
    minst = dat;
    if (TrapEn && nxt[1:0] != 2'b00) begin
      mtrap = 1'b1;
      mhalt = 1'b1;
    end else begin
      mpc   = nxt;
      mhalt = h;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_ready = 0; resp_valid = 0; resp_data = 0; redirect = 0; target = 0; halt_req = 0;
    mpc = RV; minst = NOP; mhalt = 0; mtrap = 0;
    repeat (3) tick();
    check("rst_pc", pc, RV);
    check("rst_addr", addr, RV);
    check("rst_pc_add4", pc_add4, RV + 32'd4);
    check("rst_inst", inst, NOP);
    check("rst_req_valid", req_valid, 1'b1);
    check("rst_exec_phase", exec_phase, 1'b0);
    check("rst_commit", commit, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_trap", trap, 1'b0);
    rst_n = 1'b1;

    // Zero-wait memory, then slow memory, then redirect with redirect noise during EXEC
    do_instr(0, 1, 32'h0050_0093, 1'b0, 32'h0, 1'b0, 1'b0);
    do_instr(3, 2, $urandom, 1'b0, 32'h0, 1'b0, 1'b1);
    do_instr(0, 1, $urandom, 1'b1, 32'h8000_0100, 1'b0, 1'b1);
    for (int k = 0; k < 25; k++) begin
      do_instr(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), $urandom,
               1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 1'b0,
               1'($urandom_range(0, 1)));
    end

    // PC wrap-around
    do_instr(0, 1, $urandom, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    do_instr(1, 1, $urandom, 1'b0, 32'h0, 1'b0, 1'b0);
    do_instr(0, 1, $urandom, 1'b0, 32'h0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of EXEC
    fq.push_back(mpc);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    tick();
    resp_valid = 1'b1;
    resp_data  = $urandom;
    tick();
    resp_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pc", pc, RV);
    check("midrst_inst", inst, NOP);
    check("midrst_exec_phase", exec_phase, 1'b0);
    check("midrst_req_valid", req_valid, 1'b1);
    resp_valid = 1'b1;
    resp_data  = $urandom;
    tick();
    rst_n = 1'b1;
    mpc = RV; mhalt = 0;
    do_instr(2, 1, $urandom, 1'b0, 32'h0, 1'b0, 1'b0);

    // Misaligned redirect target
    do_instr(0, 1, $urandom, 1'b1, 32'h8000_0102, 1'b0, 1'b0);
    check("misalign_trap", trap, mtrap);
    check("misalign_halted", halted, mhalt);
    check("misalign_pc", pc, mpc);
`ifdef FETCH_SEQ_TRAP_EN
    tick();
    check("trap_sticky", trap, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mpc = RV; mhalt = 0; mtrap = 0;
`else
    do_instr(0, 1, $urandom, 1'b0, 32'h0, 1'b0, 1'b0);
`endif

    // Halt request at commit, then recovery via reset
    do_instr(1, 2, $urandom, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      resp_valid = 1'b1;
      resp_data  = $urandom;
      req_ready  = 1'b1;
      redirect   = 1'b1;
      target     = $urandom;
      check("halt_halted", halted, 1'b1);
      check("halt_req_valid", req_valid, 1'b0);
      check("halt_pc", pc, mpc);
      check("halt_inst", inst, minst);
      tick();
    end
    rst_n = 1'b0;
    req_ready = 0; resp_valid = 0; redirect = 0;
    #1;
    check("halt_rst_halted", halted, 1'b0);
    check("halt_rst_pc", pc, RV);
    tick();
    rst_n = 1'b1;
    mpc = RV; mhalt = 0; mtrap = 0;
    do_instr(0, 1, $urandom, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("fetch_queue_drained", 32'(fq.size()), 32'd0);
    check("commit_queue_drained", 32'(cq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
